seq_decoder_n: RTL

SEQ_DECODER_N -- requirements
Module: seq_decoder_n

---
 rtl/seq_decoder_n.sv | 99 +++++++++
 1 files changed

// File: rtl/seq_decoder_n.sv
// Binary code decoder with one-hot, thermometer and timed scan output modes.
// Latency 1 cycle from accept to out; in_ready drops while scanning or when en is low.
module seq_decoder_n #(
    parameter int IN_W       = 2,
    parameter int SCAN_DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
    input  logic [1:0]           in_mode,
    output logic [2**IN_W-1:0]   out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 err
);
    localparam int OUT_W = 2**IN_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Dwell counter only ever reaches SCAN_DWELL-1 (max 254), so 8 bits never wrap.
    localparam logic [7:0] DWELL_LAST = 8'(SCAN_DWELL - 1);

    logic [0:0]       state;
    logic [7:0]       dwell_cnt;
    logic [IN_W-1:0]  step;
    logic [IN_W-1:0]  last_step;
    logic [IN_W-1:0]  step_nxt;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] therm;
    logic             accept;
    logic             dwell_done;

    assign in_ready   = (state == ST_IDLE) && en;
    assign busy       = (state == ST_SCAN);
    assign accept     = in_valid && in_ready;
    assign dwell_done = (dwell_cnt == DWELL_LAST);
    // step_nxt is only used while step < last_step, so the increment cannot overflow.
    assign step_nxt   = step + IN_W'(1);

    // Thermometer derived from the one-hot avoids a 2**IN_W+1 bit intermediate.
    assign onehot = OUT_W'(1) << in_code;
    assign therm  = onehot | (onehot - OUT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dwell_cnt <= '0;
            step      <= '0;
            last_step <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else if (!en) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                err       <= (in_mode == MODE_RSVD);
                out_valid <= 1'b1;
                case (in_mode)
                    MODE_THERM: out <= therm;
                    MODE_SCAN: begin
                        out       <= OUT_W'(1);
                        state     <= ST_SCAN;
                        step      <= '0;
                        last_step <= in_code;
                        dwell_cnt <= '0;
                    end
                    default: out <= onehot;
                endcase
            end else if (state == ST_SCAN) begin
                if (!dwell_done) begin
                    dwell_cnt <= dwell_cnt + 8'd1;
                end else if (step == last_step) begin
                    state     <= ST_IDLE;
                    dwell_cnt <= '0;
                    step      <= '0;
                end else begin
                    step      <= step_nxt;
                    out       <= OUT_W'(1) << step_nxt;
                    out_valid <= 1'b1;
                    dwell_cnt <= '0;
                end
            end
        end
    end

    logic unused_mode_onehot;
    assign unused_mode_onehot = (MODE_ONEHOT == 2'b00);
endmodule
